ysyx_040750_muldiv_unit: RTL and testbench
==========================================

// Module: ysyx_040750_muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage. Executes RV64M mul/mulh/mulhsu/mulhu,
//  div/divu/rem/remu and their W forms. valid/ready handshake on both sides and flush support.
//  Result is held in an internal output register until consumed, so there is no external result cache.
//  Sits beside the single-cycle ALU and is selected by the decoder for M-extension ops.
// PARAMETERS
//  XLEN      64  operand/result width (32 or 64)
//  MUL_STEP  1   multiplier bits retired per cycle (1, 2 or 4; must divide XLEN)
//  TAG_W     5   width of the opaque tag (e.g. rd index) carried with each op
// PORTS
//  I_sys_clk    in   1        clock
//  I_rst        in   1        async reset, active-high
//  I_in_valid   in   1        op request
//  O_in_ready   out  1        unit can accept an op this cycle
//  I_op1        in   XLEN     operand 1 (rs1)
//  I_op2        in   XLEN     operand 2 (rs2)
//  I_func       in   2        00 mul-lo, 01 mul-hi, 10 div, 11 rem
//  I_sext       in   2        [1] op1 signed, [0] op2 signed
//  I_word_op    in   1        W-form: use op[31:0], sign-extend result bit 31
//  I_tag        in   TAG_W    returned unchanged on O_tag
//  I_flush      in   1        kill in-flight/pending op
//  O_out_valid  out  1        O_result/O_tag valid
//  I_out_ready  in   1        consumer takes the result
//  O_result     out  XLEN     result
//  O_tag        out  TAG_W    tag of the op in O_result
//  O_busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, any time, including mid-op): state=IDLE, O_out_valid=0, O_result=0, O_tag=0, O_busy=0.
//    O_in_ready=1 after reset.
//  - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//    Accept = I_in_valid & O_in_ready.
//    O_in_ready = (IDLE) | (DONE & I_out_ready), which allows back-to-back ops.
//  - On accept, latch func/sext/word/tag. Operands are pre-extended to XLEN:
//    word ops use {32{sext?op[31]:0},op[31:0]}. Convert to magnitudes and record the result sign.
//  - CALC mul: unsigned shift-add, MUL_STEP bits/cycle, XLEN/MUL_STEP cycles, 2*XLEN accumulator.
//  - CALC div: restoring on magnitudes, 1 bit/cycle, XLEN cycles.
//  - FIX (1 cycle) applies the sign corrections:
//    product negated if sign1^sign2; quotient negated if sign1^sign2; remainder takes the sign of op1.
//    It then selects the lo/hi half or the quotient/remainder. For word ops the result is
//    {32{r[31]}, r[31:0]}, including divuw/remuw.
//  - DONE: O_out_valid=1, O_result/O_tag stable until I_out_ready=1.
//  - Latency, accept cycle to first O_out_valid: mul XLEN/MUL_STEP+2; div/rem XLEN+2.
//  - Special cases bypass CALC/FIX; DONE is entered the cycle after accept (latency 1).
//    Checks use 32-bit values when I_word_op=1.
//    - Divide by zero: quotient = all ones (then word-extended); remainder = op1 (extended).
//    - Signed overflow (MIN / -1, both signed): quotient = MIN; remainder = 0.
//  - I_flush: next state IDLE and O_out_valid=0 on the following edge.
//    Flush wins over a same-cycle accept (the op is dropped) and over I_out_ready.
//    Flush in IDLE is a no-op.
//  - O_out_valid never drops without a handshake or a flush/reset.
//  - Simultaneous DONE handshake and new accept: the new op enters CALC (or DONE if special)
//    on the same edge that retires the old one.
//  - Unsupported I_func does not exist (2-bit full encoding). sext bits are ignored for mul-lo.
// STRUCTURE
//  - Package ysyx_040750_muldiv_pkg holds:
//    - the func encodings (MD_MUL, MD_MULH, MD_DIV, MD_REM);
//    - the FSM state enum (S_IDLE, S_CALC, S_FIX, S_DONE);
//    - the helper function sext_w().
//  - One sub-module, ysyx_040750_md_iter_core: shared 2*XLEN datapath with step counter.
//    It performs the MUL_STEP shift-add and the 1-bit restoring subtract and asserts last_step.
//    The top holds the FSM, sign/special-case logic, FIX and the output register.
// TESTING  (XLEN=64, MUL_STEP=1)
//  1. Signed multiply, mul and mulh, sext=11: op1=0xFFFF_FFFF_FFFF_FFFD, op2=7.
//     mul -> 0xFFFF_FFFF_FFFF_FFEB; mulh -> 0xFFFF_FFFF_FFFF_FFFF.
//     O_out_valid exactly 66 cycles after accept.
//  2. mulhu, sext=00: op1=op2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
//     mulw 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE.
//  3. Divide by zero, divu 5/0:
//     -> 0xFFFF_FFFF_FFFF_FFFF, remu -> 5, latency 1;
//     divuw 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF (66 cycles).
//  4. Signed overflow:
//     div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, rem -> 0;
//     divw 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
//  5. Backpressure: hold I_out_ready=0 for 10 cycles in DONE.
//     Result and tag stay stable; O_in_ready stays 0.
//     Then assert I_out_ready together with I_in_valid: old op retires, new op accepted on the same edge.
//  6. Flush/reset mid-op:
//     - I_flush 20 cycles into a div: no O_out_valid follows; O_in_ready=1 next cycle.
//     - I_rst pulsed between edges mid-mul: all outputs 0 immediately; a fresh op then completes correctly.

Source files
------------

// File: rtl/ysyx_040750_muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package ysyx_040750_muldiv_pkg;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULH = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_REM  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [63:0] sext_w(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_040750_md_iter_core.sv
// Shared 2*XLEN iteration datapath: shift-add multiply or restoring divide on magnitudes.
module ysyx_040750_md_iter_core #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                step_i,
  input  logic                is_div_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [2*XLEN-1:0]   acc_o,
  output logic                last_step_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] MulLast = CntW'(XLEN / MUL_STEP - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);

  logic [2*XLEN-1:0] acc_q, acc_d, mul_nxt, div_nxt, mul_t;
  logic [XLEN:0]     mul_sum, rem_ext, diff;
  logic [XLEN-1:0]   b_q, b_d;
  logic              div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // acc = {hi, multiplier}; each retired bit adds b into hi, then the whole pair shifts right.
  always_comb begin
    mul_t   = acc_q;
    mul_sum = '0;
    for (int k = 0; k < int'(MUL_STEP); k++) begin
      mul_sum = {1'b0, mul_t[2*XLEN-1:XLEN]} + {1'b0, (mul_t[0] ? b_q : {XLEN{1'b0}})};
      mul_t   = {mul_sum, mul_t[XLEN-1:1]};
    end
    mul_nxt = mul_t;
  end

  // acc = {remainder, dividend/quotient}; shifted remainder keeps its carry-out bit.
  always_comb begin
    rem_ext = acc_q[2*XLEN-1:XLEN-1];
    diff    = rem_ext - {1'b0, b_q};
    div_nxt = diff[XLEN] ? {rem_ext[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    b_d   = b_q;
    div_d = div_q;
    if (start_i) begin
      acc_d = {{XLEN{1'b0}}, a_i};
      cnt_d = '0;
      b_d   = b_i;
      div_d = is_div_i;
    end else if (step_i) begin
      acc_d = div_q ? div_nxt : mul_nxt;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign acc_o       = acc_q;
  assign last_step_o = (cnt_q == (div_q ? DivLast : MulLast));

endmodule

// File: rtl/ysyx_040750_muldiv_unit.sv
// RV64M multiply/divide unit: FSM, sign and special-case handling, result register.
module ysyx_040750_muldiv_unit
  import ysyx_040750_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MUL_STEP = 1,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             I_sys_clk,
  input  logic             I_rst,
  input  logic             I_in_valid,
  output logic             O_in_ready,
  input  logic [XLEN-1:0]  I_op1,
  input  logic [XLEN-1:0]  I_op2,
  input  logic [1:0]       I_func,
  input  logic [1:0]       I_sext,
  input  logic             I_word_op,
  input  logic [TAG_W-1:0] I_tag,
  input  logic             I_flush,
  output logic             O_out_valid,
  input  logic             I_out_ready,
  output logic [XLEN-1:0]  O_result,
  output logic [TAG_W-1:0] O_tag,
  output logic             O_busy
);

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d, func_q, func_d;
  logic              word_q, word_d, neg_q, neg_d, s1_q, s1_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   op1_x, op2_x, mag1, mag2, spec_r, fix_r, quot, remd;
  logic [2*XLEN-1:0] acc, prod;
  logic              sgn1, sgn2, div0, ovf, special, accept, core_start, last_step;

  function automatic logic [XLEN-1:0] wext(input logic w, input logic [XLEN-1:0] r);
    return w ? XLEN'(sext_w(64'(r))) : r;
  endfunction

  always_comb begin
    op1_x = I_word_op ? (I_sext[1] ? XLEN'($signed(I_op1[31:0])) : XLEN'(I_op1[31:0])) : I_op1;
    op2_x = I_word_op ? (I_sext[0] ? XLEN'($signed(I_op2[31:0])) : XLEN'(I_op2[31:0])) : I_op2;
    // Low product half is sign-independent, so mul-lo runs purely unsigned.
    sgn1  = I_sext[1] & (I_func != MD_MUL) & op1_x[XLEN-1];
    sgn2  = I_sext[0] & (I_func != MD_MUL) & op2_x[XLEN-1];
    mag1  = sgn1 ? -op1_x : op1_x;
    mag2  = sgn2 ? -op2_x : op2_x;
    div0  = I_word_op ? ~|I_op2[31:0] : ~|I_op2;
    ovf   = (I_sext == 2'b11) &
            (I_word_op ? ((I_op1[31:0] == 32'h8000_0000) & (&I_op2[31:0]))
                       : ((I_op1 == MinVal) & (&I_op2)));
    special = I_func[1] & (div0 | ovf);
    if (div0) spec_r = (I_func == MD_REM) ? op1_x : {XLEN{1'b1}};
    else      spec_r = (I_func == MD_REM) ? {XLEN{1'b0}} : op1_x;
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remd = s1_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    unique case (func_q)
      MD_MUL:  fix_r = prod[XLEN-1:0];
      MD_MULH: fix_r = prod[2*XLEN-1:XLEN];
      MD_DIV:  fix_r = quot;
      default: fix_r = remd;
    endcase
  end

  assign O_in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & I_out_ready);
  assign accept     = I_in_valid & O_in_ready & ~I_flush;

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    word_d     = word_q;
    neg_d      = neg_q;
    s1_d       = s1_q;
    tag_d      = tag_q;
    result_d   = result_q;
    core_start = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_CALC: if (last_step) state_d = S_FIX;
      S_FIX: begin
        state_d  = S_DONE;
        result_d = wext(word_q, fix_r);
      end
      default: if (I_out_ready) state_d = S_IDLE;
    endcase
    // A DONE handshake and a new accept share one edge.
    if (accept) begin
      func_d = I_func;
      word_d = I_word_op;
      neg_d  = sgn1 ^ sgn2;
      s1_d   = sgn1;
      tag_d  = I_tag;
      if (special) begin
        state_d  = S_DONE;
        result_d = wext(I_word_op, spec_r);
      end else begin
        state_d    = S_CALC;
        core_start = 1'b1;
      end
    end
    if (I_flush) state_d = S_IDLE;
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q  <= S_IDLE;
      func_q   <= MD_MUL;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      s1_q     <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      s1_q     <= s1_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  ysyx_040750_md_iter_core #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_core (
    .clk_i       (I_sys_clk),
    .rst_i       (I_rst),
    .start_i     (core_start),
    .step_i      (state_q == S_CALC),
    .is_div_i    (I_func[1]),
    .a_i         (mag1),
    .b_i         (mag2),
    .acc_o       (acc),
    .last_step_o (last_step)
  );

  assign O_out_valid = (state_q == S_DONE);
  assign O_busy      = (state_q != S_IDLE);
  assign O_result    = result_q;
  assign O_tag       = tag_q;

endmodule

// File: tb/tb_ysyx_040750_muldiv_unit.sv
// Directed plus randomized check of the multiply/divide unit against an arithmetic reference.
module tb_ysyx_040750_muldiv_unit;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned MUL_STEP = 1;
  localparam int unsigned TAG_W    = 5;
  localparam int          CalcLat  = 66;

  logic             clk = 1'b0, rst = 1'b1;
  logic             in_valid = 1'b0, in_ready, word_op = 1'b0, flush = 1'b0;
  logic             out_valid, out_ready = 1'b0, busy;
  logic [XLEN-1:0]  op1 = '0, op2 = '0, result;
  logic [1:0]       func = 2'b00, sext = 2'b00;
  logic [TAG_W-1:0] tag = '0, otag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_040750_muldiv_unit #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP),
    .TAG_W    (TAG_W)
  ) dut (
    .I_sys_clk   (clk),
    .I_rst       (rst),
    .I_in_valid  (in_valid),
    .O_in_ready  (in_ready),
    .I_op1       (op1),
    .I_op2       (op2),
    .I_func      (func),
    .I_sext      (sext),
    .I_word_op   (word_op),
    .I_tag       (tag),
    .I_flush     (flush),
    .O_out_valid (out_valid),
    .I_out_ready (out_ready),
    .O_result    (result),
    .O_tag       (otag),
    .O_busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext_op(input logic w, input logic s, input logic [63:0] v);
    if (!w) return v;
    return s ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
  endfunction

  function automatic logic is_special(input logic [1:0] f, input logic [1:0] s, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ax, bx;
    ax = ext_op(w, s[1], a);
    bx = ext_op(w, s[0], b);
    if (!f[1]) return 1'b0;
    if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1'b1;
    return (s == 2'b11) && (bx == '1) &&
           (ax == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  endfunction

  // Reference: true signed/unsigned arithmetic on widened operands, then truncate.
  function automatic logic [63:0] model(input logic [1:0] f, input logic [1:0] s, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0]         ax, bx, r;
    logic signed [127:0] pa, pb, p;
    logic signed [65:0]  da, db, q, m;
    ax = ext_op(w, s[1], a);
    bx = ext_op(w, s[0], b);
    if (!f[1]) begin
      pa = s[1] ? {{64{ax[63]}}, ax} : {64'b0, ax};
      pb = s[0] ? {{64{bx[63]}}, bx} : {64'b0, bx};
      p  = pa * pb;
      r  = f[0] ? p[127:64] : p[63:0];
    end else if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) begin
      r = f[0] ? ax : '1;
    end else if (is_special(f, s, w, a, b)) begin
      r = f[0] ? 64'd0 : ax;
    end else begin
      da = s[1] ? {{2{ax[63]}}, ax} : {2'b0, ax};
      db = s[0] ? {{2{bx[63]}}, bx} : {2'b0, bx};
      q  = da / db;
      m  = da % db;
      r  = f[0] ? m[63:0] : q[63:0];
    end
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  task automatic drive(input logic [1:0] f, input logic [1:0] s, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
    func = f; sext = s; word_op = w; op1 = a; op2 = b; tag = t;
    in_valid = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] f, input logic [1:0] s,
                        input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input logic [63:0] exp, input int exp_lat);
    int lat;
    drive(f, s, w, a, b, t);
    chk({name, "/in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk({name, "/latency"}, lat, exp_lat);
    chk({name, "/result"}, result, exp);
    chk({name, "/tag"}, otag, t);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "/retired"}, out_valid, 0);
  endtask

  initial begin
    logic [1:0]       rf, rs;
    logic             rw;
    logic [63:0]      ra, rb;
    logic [TAG_W-1:0] rt;
    int               lat, seen;

    #2;
    chk("reset/out_valid", out_valid, 0);
    chk("reset/result", result, 0);
    chk("reset/tag", otag, 0);
    chk("reset/busy", busy, 0);
    chk("reset/in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul_neg", 2'b00, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd1,
           64'hFFFF_FFFF_FFFF_FFEB, CalcLat);
    run_op("mulh_neg", 2'b01, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd2,
           64'hFFFF_FFFF_FFFF_FFFF, CalcLat);
    run_op("mulhu_max", 2'b01, 2'b00, 1'b0, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, CalcLat);
    run_op("mulw", 2'b00, 2'b11, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4,
           64'hFFFF_FFFF_FFFF_FFFE, CalcLat);
    run_op("divu_zero", 2'b10, 2'b00, 1'b0, 64'd5, 64'd0, 5'd5, '1, 1);
    run_op("remu_zero", 2'b11, 2'b00, 1'b0, 64'd5, 64'd0, 5'd6, 64'd5, 1);
    run_op("divuw", 2'b10, 2'b00, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd7, '1, CalcLat);
    run_op("div_ovf", 2'b10, 2'b11, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd8,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 2'b11, 2'b11, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd9, 64'd0, 1);
    run_op("divw_ovf", 2'b10, 2'b11, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd10,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("rem_signed", 2'b11, 2'b11, 1'b0, -64'sd17, 64'd5, 5'd11, -64'sd2, CalcLat);

    // Backpressure: result held in DONE, then retire and accept on one edge.
    drive(2'b00, 2'b11, 1'b0, 64'd3, 64'd5, 5'd12);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp/latency", lat, CalcLat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp/hold_valid", out_valid, 1);
      chk("bp/hold_result", result, 64'd15);
      chk("bp/hold_tag", otag, 12);
      chk("bp/hold_in_ready", in_ready, 0);
    end
    drive(2'b10, 2'b00, 1'b0, 64'd7, 64'd0, 5'd21);
    out_ready = 1'b1;
    #1;
    chk("bp/in_ready_on_handshake", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp/new_valid", out_valid, 1);
    chk("bp/new_result", result, '1);
    chk("bp/new_tag", otag, 21);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp/drained", out_valid, 0);

    // Flush mid-divide.
    drive(2'b10, 2'b00, 1'b0, 64'd100, 64'd7, 5'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush/out_valid", out_valid, 0);
    chk("flush/in_ready", in_ready, 1);
    chk("flush/busy", busy, 0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    chk("flush/no_late_valid", seen, 0);

    // Flush beats a same-cycle accept.
    drive(2'b10, 2'b00, 1'b0, 64'd9, 64'd0, 5'd4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_accept/busy", busy, 0);
    chk("flush_accept/out_valid", out_valid, 0);

    // Asynchronous reset between edges mid-multiply.
    drive(2'b00, 2'b00, 1'b0, 64'd1234, 64'd5678, 5'd17);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid/out_valid", out_valid, 0);
    chk("rst_mid/result", result, 0);
    chk("rst_mid/tag", otag, 0);
    chk("rst_mid/busy", busy, 0);
    chk("rst_mid/in_ready", in_ready, 1);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst", 2'b00, 2'b00, 1'b0, 64'd1234, 64'd5678, 5'd18, 64'd7006652, CalcLat);

    for (int i = 0; i < 40; i++) begin
      rf = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rt = TAG_W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 64'd0;
        1: rb = '1;
        2: ra = rw ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        3: begin ra = 64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 40)); end
        default: ;
      endcase
      run_op("random", rf, rs, rw, ra, rb, rt, model(rf, rs, rw, ra, rb),
             is_special(rf, rs, rw, ra, rb) ? 1 : CalcLat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
